// File: rtl/trace_encoder.sv
// rtl/trace_encoder.sv - execution-trace encoder: strobe decode, record FIFO, valid/ready drain
// Optional macro TRACE_ZFLAG_EN adds the z_flag input and a z field at the record MSB.
`ifndef OP_LOAD
`define OP_LOAD  0
`define OP_STORE 1
`define OP_ADD   2
`define OP_SUB   3
`define OP_XOR   4
`define OP_LOADI 5
`define OP_LOADR 6
`define OP_BNE   7
`endif

module trace_encoder #(
  parameter int PC_W  = 8,
  parameter int OP_W  = 3,
  parameter int DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 n_reset,
  input  logic                 load_IR,
  input  logic                 load_PC,
  input  logic                 load_REG,
  input  logic                 ALU_REG,
  input  logic                 ALU_add,
  input  logic                 ALU_sub,
  input  logic                 ALU_xor,
  input  logic                 INC_PC,
  input  logic                 WE,
  input  logic                 IMM,
  input  logic                 IND,
  input  logic [PC_W-1:0]      pc,
`ifdef TRACE_ZFLAG_EN
  input  logic                 z_flag,
  input  logic                 t_ready,
  output logic                 t_valid,
  output logic [PC_W+OP_W+3:0] t_data,
`else
  input  logic                 t_ready,
  output logic                 t_valid,
  output logic [PC_W+OP_W+2:0] t_data,
`endif
  output logic                 err_sticky,
  output logic [7:0]           drop_count
);

  localparam int AW = $clog2(DEPTH);
`ifdef TRACE_ZFLAG_EN
  localparam int REC_W = PC_W + OP_W + 4;
`else
  localparam int REC_W = PC_W + OP_W + 3;
`endif

  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(`OP_LOAD);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(`OP_STORE);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(`OP_ADD);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(`OP_SUB);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(`OP_XOR);
  localparam logic [OP_W-1:0] OP_LOADI = OP_W'(`OP_LOADI);
  localparam logic [OP_W-1:0] OP_LOADR = OP_W'(`OP_LOADR);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(`OP_BNE);

  typedef enum logic {WAIT_FETCH = 1'b0, WAIT_EXEC = 1'b1} state_t;

  state_t            state, state_next;
  logic [PC_W-1:0]   ipc;
  logic              push, latch_ipc;
  logic              rec_err, rec_amb, rec_taken;
  logic [OP_W-1:0]   rec_op, cls_op;
  logic              cls_amb, cls_taken;
  logic [PC_W-1:0]   rec_pc;
  logic              strobe_bad;
  logic [REC_W-1:0]  rec;
  logic [REC_W-1:0]  mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              empty, full, pop, accept;

  // Strobe combinations the controller can never legally produce together.
  assign strobe_bad = (ALU_add & ALU_sub) | (ALU_add & ALU_xor) | (ALU_sub & ALU_xor)
                    | (ALU_REG & ~load_REG)
                    | (WE & load_REG)
                    | (IMM & IND) | (IMM & ALU_REG) | (IND & ALU_REG);

  always_comb begin
    cls_op    = OP_BNE;
    cls_amb   = 1'b0;
    cls_taken = 1'b0;
    if (WE)                                 cls_op = OP_STORE;
    else if (load_REG && IND)               cls_op = OP_LOADR;
    else if (load_REG && IMM)               cls_op = OP_LOADI;
    else if (load_REG && ALU_REG && ALU_add) cls_op = OP_ADD;
    else if (load_REG && ALU_REG && ALU_sub) cls_op = OP_SUB;
    else if (load_REG && ALU_REG && ALU_xor) cls_op = OP_XOR;
    else if (load_REG)                      cls_op = OP_LOAD;
    else if (!INC_PC)                       cls_taken = 1'b1;
    else                                    cls_amb = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!n_reset) state <= WAIT_FETCH;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      WAIT_FETCH: if (load_IR && !load_PC) state_next = WAIT_EXEC;
      WAIT_EXEC:  if (load_PC)             state_next = WAIT_FETCH;
      default:    state_next = WAIT_FETCH;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    latch_ipc = 1'b0;
    rec_err   = 1'b0;
    rec_amb   = 1'b0;
    rec_taken = 1'b0;
    rec_op    = '0;
    rec_pc    = ipc;
    unique case (state)
      WAIT_FETCH: begin
        if (load_PC) begin
          push    = 1'b1;
          rec_err = 1'b1;
          rec_pc  = pc;
        end else if (load_IR) begin
          latch_ipc = 1'b1;
        end
      end
      WAIT_EXEC: begin
        if (load_IR && load_PC) begin
          push    = 1'b1;
          rec_err = 1'b1;
          rec_pc  = pc;
        end else if (load_PC) begin
          push = 1'b1;
          if (strobe_bad) begin
            rec_err = 1'b1;
          end else begin
            rec_op    = cls_op;
            rec_amb   = cls_amb;
            rec_taken = cls_taken;
          end
        end else if (load_IR) begin
          // Refetch without execute: report the abandoned address, then track the new one.
          push      = 1'b1;
          rec_err   = 1'b1;
          latch_ipc = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef TRACE_ZFLAG_EN
  assign rec = {z_flag, rec_err, rec_amb, rec_taken, rec_op, rec_pc};
`else
  assign rec = {rec_err, rec_amb, rec_taken, rec_op, rec_pc};
`endif

  always_ff @(posedge clock) begin
    if (!n_reset) ipc <= '0;
    else if (latch_ipc) ipc <= pc;
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign t_valid = !empty;
  assign pop     = t_valid && t_ready;
  assign accept  = push && (!full || pop);
  assign t_data  = t_valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      drop_count <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr[AW-1:0]] <= rec;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push && !accept && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      if (push && rec_err) err_sticky <= 1'b1;
    end
  end

endmodule
